// File: rtl/yacht_pkg.sv
// Shared Yacht definitions: category indices, fixed scores, die width and the
// evaluator state encoding. The game controller imports the same category constants.
package yacht_pkg;

    localparam int DIE_W = 3;
    localparam int CAT_W = 4;
    localparam int SUM_W = 5;

    localparam logic [CAT_W-1:0] CAT_ONES      = 4'd0;
    localparam logic [CAT_W-1:0] CAT_TWOS      = 4'd1;
    localparam logic [CAT_W-1:0] CAT_THREES    = 4'd2;
    localparam logic [CAT_W-1:0] CAT_FOURS     = 4'd3;
    localparam logic [CAT_W-1:0] CAT_FIVES     = 4'd4;
    localparam logic [CAT_W-1:0] CAT_SIXES     = 4'd5;
    localparam logic [CAT_W-1:0] CAT_CHOICE    = 4'd6;
    localparam logic [CAT_W-1:0] CAT_FOUR_KIND = 4'd7;
    localparam logic [CAT_W-1:0] CAT_FULL_HOUSE = 4'd8;
    localparam logic [CAT_W-1:0] CAT_SSTRAIGHT = 4'd9;
    localparam logic [CAT_W-1:0] CAT_LSTRAIGHT = 4'd10;
    localparam logic [CAT_W-1:0] CAT_YACHT     = 4'd11;

    localparam logic [7:0] SCORE_SSTRAIGHT = 8'd15;
    localparam logic [7:0] SCORE_LSTRAIGHT = 8'd30;
    localparam logic [7:0] SCORE_YACHT     = 8'd50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EVAL  = 2'd2
    } state_t;

endpackage

// File: rtl/yacht_histogram.sv
// Six 3-bit face counters (index 0 = face 1). Clear wins over increment;
// faces 0 and 7 are ignored.
module yacht_histogram
    import yacht_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   inc,
    input  logic [DIE_W-1:0]       face,
    output logic [5:0][DIE_W-1:0]  counts
);

    logic [5:0][DIE_W-1:0] counts_d, counts_q;

    always_comb begin
        counts_d = counts_q;
        if (clr) begin
            counts_d = '0;
        end else if (inc) begin
            for (int i = 0; i < 6; i++) begin
                if (face == DIE_W'(i + 1)) begin
                    counts_d[i] = counts_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counts_q <= '0;
        end else begin
            counts_q <= counts_d;
        end
    end

    assign counts = counts_q;

endmodule

// File: rtl/yacht_score_calc.sv
// Yacht score evaluator: snapshots dice/category, histograms one die per cycle,
// then scores the category. Optional face range check under YACHT_DICE_RANGE_CHK_EN.
module yacht_score_calc
    import yacht_pkg::*;
#(
    parameter int NUM_DICE = 5,
    parameter int NUM_CAT  = 12
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_DICE*DIE_W-1:0]   dice,
    input  logic [CAT_W-1:0]            category_idx,
    output logic [7:0]                  calc_score,
    output logic                        score_valid,
    output logic                        busy,
    output logic                        dice_err
);

    localparam logic [2:0] LAST_DIE = 3'(NUM_DICE - 1);

    state_t                       state_d, state_q;
    logic [NUM_DICE*DIE_W-1:0]    snap_dice_d, snap_dice_q;
    logic [CAT_W-1:0]             snap_cat_d, snap_cat_q;
    logic                         start_pending_d, start_pending_q;
    logic [2:0]                   die_cnt_d, die_cnt_q;
    logic [SUM_W-1:0]             sum_d, sum_q;
    logic [7:0]                   calc_score_d, calc_score_q;
    logic                         score_valid_d, score_valid_q;

    logic                         hist_clr, hist_inc, capture, inputs_changed;
    logic [DIE_W-1:0]             cur_face;
    logic [5:0][DIE_W-1:0]        counts;
    logic [5:0]                   present;
    logic                         any4, any5, has3, has2;
    logic [4:0]                   upper;
    logic [7:0]                   eval_score;

    assign inputs_changed = (dice != snap_dice_q) || (category_idx != snap_cat_q);
    assign cur_face       = snap_dice_q[die_cnt_q*DIE_W +: DIE_W];

    yacht_histogram u_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (hist_clr),
        .inc     (hist_inc),
        .face    (cur_face),
        .counts  (counts)
    );

    // Category scoring from the finished histogram and running sum.
    always_comb begin
        upper   = '0;
        present = '0;
        any4    = 1'b0;
        any5    = 1'b0;
        has3    = 1'b0;
        has2    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            present[i] = (counts[i] != '0);
            if (counts[i] >= 3'd4) any4 = 1'b1;
            if (counts[i] == 3'd5) any5 = 1'b1;
            if (counts[i] == 3'd3) has3 = 1'b1;
            if (counts[i] == 3'd2) has2 = 1'b1;
            if (snap_cat_q == CAT_W'(i)) upper = {2'b00, counts[i]} * 5'(i + 1);
        end
        eval_score = '0;
        if (snap_cat_q < CAT_W'(NUM_CAT)) begin
            case (snap_cat_q)
                CAT_ONES, CAT_TWOS, CAT_THREES,
                CAT_FOURS, CAT_FIVES, CAT_SIXES: eval_score = {3'b000, upper};
                CAT_CHOICE:     eval_score = {3'b000, sum_q};
                CAT_FOUR_KIND:  eval_score = any4 ? {3'b000, sum_q} : 8'd0;
                CAT_FULL_HOUSE: eval_score = (has3 && has2) ? {3'b000, sum_q} : 8'd0;
                CAT_SSTRAIGHT:  eval_score = ((&present[3:0]) || (&present[4:1]) || (&present[5:2]))
                                             ? SCORE_SSTRAIGHT : 8'd0;
                CAT_LSTRAIGHT:  eval_score = ((&present[4:0]) || (&present[5:1]))
                                             ? SCORE_LSTRAIGHT : 8'd0;
                CAT_YACHT:      eval_score = any5 ? SCORE_YACHT : 8'd0;
                default:        eval_score = '0;
            endcase
        end
    end

`ifdef YACHT_DICE_RANGE_CHK_EN
    logic range_err;
    logic dice_err_d, dice_err_q;

    always_comb begin
        range_err = 1'b0;
        for (int k = 0; k < NUM_DICE; k++) begin
            if (snap_dice_q[k*DIE_W +: DIE_W] == 3'd0 || snap_dice_q[k*DIE_W +: DIE_W] == 3'd7) begin
                range_err = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d         = state_q;
        snap_dice_d     = snap_dice_q;
        snap_cat_d      = snap_cat_q;
        start_pending_d = start_pending_q;
        die_cnt_d       = die_cnt_q;
        sum_d           = sum_q;
        calc_score_d    = calc_score_q;
        score_valid_d   = score_valid_q;
`ifdef YACHT_DICE_RANGE_CHK_EN
        dice_err_d      = dice_err_q;
`endif
        hist_clr        = 1'b0;
        hist_inc        = 1'b0;
        capture         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inputs_changed || start_pending_q) capture = 1'b1;
            end
            ST_COUNT: begin
                if (inputs_changed) begin
                    capture = 1'b1;
                end else begin
                    hist_inc = 1'b1;
                    sum_d    = sum_q + {2'b00, cur_face};
                    if (die_cnt_q == LAST_DIE) state_d = ST_EVAL;
                    else                       die_cnt_d = die_cnt_q + 3'd1;
                end
            end
            ST_EVAL: begin
                if (inputs_changed) begin
                    capture = 1'b1;
                end else begin
`ifdef YACHT_DICE_RANGE_CHK_EN
                    calc_score_d = range_err ? 8'd0 : eval_score;
                    dice_err_d   = range_err;
`else
                    calc_score_d = eval_score;
`endif
                    score_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A single capture path covers both fresh starts and mid-evaluation restarts.
        if (capture) begin
            snap_dice_d     = dice;
            snap_cat_d      = category_idx;
            start_pending_d = 1'b0;
            hist_clr        = 1'b1;
            die_cnt_d       = '0;
            sum_d           = '0;
            score_valid_d   = 1'b0;
            state_d         = ST_COUNT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            snap_dice_q     <= '0;
            snap_cat_q      <= '0;
            start_pending_q <= 1'b1;
            die_cnt_q       <= '0;
            sum_q           <= '0;
            calc_score_q    <= '0;
            score_valid_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            snap_dice_q     <= snap_dice_d;
            snap_cat_q      <= snap_cat_d;
            start_pending_q <= start_pending_d;
            die_cnt_q       <= die_cnt_d;
            sum_q           <= sum_d;
            calc_score_q    <= calc_score_d;
            score_valid_q   <= score_valid_d;
        end
    end

`ifdef YACHT_DICE_RANGE_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dice_err_q <= 1'b0;
        else          dice_err_q <= dice_err_d;
    end
    assign dice_err = dice_err_q;
`else
    assign dice_err = 1'b0;
`endif

    assign calc_score  = calc_score_q;
    assign score_valid = score_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_yacht_score_calc.sv
// Directed bench for yacht_score_calc: expected scores queue at drive time and are
// compared when score_valid rises, along with latency and reset behaviour.
module tb_yacht_score_calc;

    logic        clk;
    logic        reset_n;
    logic [14:0] dice;
    logic [3:0]  category_idx;
    logic [7:0]  calc_score;
    logic        score_valid;
    logic        busy;
    logic        dice_err;

    logic [7:0] exp_q[$];
    logic       exp_err_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    yacht_score_calc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dice         (dice),
        .category_idx (category_idx),
        .calc_score   (calc_score),
        .score_valid  (score_valid),
        .busy         (busy),
        .dice_err     (dice_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [14:0] d, input logic [3:0] c, input logic [7:0] exp, input logic exp_err);
        dice         = d;
        category_idx = c;
        exp_q.push_back(exp);
        exp_err_q.push_back(exp_err);
    endtask

    // Waits (bounded) for score_valid, then checks latency and pops the scoreboard.
    task automatic wait_result(input string tag, input int exp_lat);
        int   lat;
        logic got;
        logic [7:0] e_score;
        logic       e_err;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_valid_drop"}, score_valid, 0);
                check({tag, "_busy"}, busy, 1);
            end
            if (score_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        check({tag, "_valid_seen"}, got, 1);
        check({tag, "_latency"}, lat, exp_lat);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            e_score = exp_q.pop_front();
            e_err   = exp_err_q.pop_front();
            check({tag, "_score"}, calc_score, e_score);
            check({tag, "_dice_err"}, dice_err, e_err);
            check({tag, "_busy_done"}, busy, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(pk(3, 3, 3, 5, 5), 4'd8, 8'd19, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_score", calc_score, 0);
        check("rst_valid", score_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", dice_err, 0);
        reset_n = 1'b1;
        wait_result("fh_release", 7);

        drive(pk(1, 2, 3, 4, 6), 4'd9, 8'd15, 1'b0);  wait_result("sstraight", 7);
        drive(pk(1, 2, 3, 4, 6), 4'd10, 8'd0, 1'b0);  wait_result("lstraight_no", 7);

        drive(pk(6, 6, 6, 6, 6), 4'd11, 8'd50, 1'b0); wait_result("yacht", 7);
        drive(pk(6, 6, 6, 6, 6), 4'd7, 8'd30, 1'b0);  wait_result("fourkind_6s", 7);
        drive(pk(6, 6, 6, 6, 6), 4'd8, 8'd0, 1'b0);   wait_result("fh_five_kind", 7);
        drive(pk(6, 6, 6, 6, 6), 4'd5, 8'd30, 1'b0);  wait_result("sixes", 7);

        drive(pk(1, 1, 2, 3, 1), 4'd0, 8'd3, 1'b0);   wait_result("ones", 7);
        drive(pk(1, 1, 2, 3, 1), 4'd1, 8'd2, 1'b0);   wait_result("twos", 7);
        drive(pk(1, 1, 2, 3, 1), 4'd6, 8'd8, 1'b0);   wait_result("choice", 7);

        drive(pk(2, 3, 4, 5, 6), 4'd10, 8'd30, 1'b0); wait_result("lstraight", 7);
        drive(pk(2, 3, 4, 5, 6), 4'd9, 8'd15, 1'b0);  wait_result("sstraight_hi", 7);

        drive(pk(2, 2, 4, 4, 4), 4'd8, 8'd16, 1'b0);  wait_result("fullhouse", 7);
        drive(pk(2, 2, 4, 4, 4), 4'd7, 8'd0, 1'b0);   wait_result("fourkind_no", 7);
        drive(pk(2, 2, 4, 4, 4), 4'd12, 8'd0, 1'b0);  wait_result("cat12", 7);

        // Mid-COUNT dice change: only the second snapshot may publish.
        dice         = pk(2, 2, 2, 2, 1);
        category_idx = 4'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("restart_no_publish", score_valid, 0);
        end
        drive(pk(4, 4, 4, 4, 1), 4'd7, 8'd17, 1'b0);
        wait_result("restart", 7);

        // Reset landing in EVAL clears everything asynchronously.
        dice         = pk(3, 1, 4, 1, 5);
        category_idx = 4'd6;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("eval_rst_score", calc_score, 0);
        check("eval_rst_valid", score_valid, 0);
        check("eval_rst_busy", busy, 0);
        check("eval_rst_err", dice_err, 0);
        @(negedge clk);
        drive(pk(3, 1, 4, 1, 5), 4'd13, 8'd0, 1'b0);
        reset_n = 1'b1;
        wait_result("cat13_after_rst", 7);

`ifdef YACHT_DICE_RANGE_CHK_EN
        drive(pk(0, 1, 1, 1, 1), 4'd0, 8'd0, 1'b1);
`else
        drive(pk(0, 1, 1, 1, 1), 4'd0, 8'd4, 1'b0);
`endif
        wait_result("face0", 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/yacht_score_calc.md
# yacht_score_calc

Sequential score evaluator sitting directly upstream of the game controller's `current_calc_score` input. It watches the five current dice faces and the category index under selection. Whenever either changes, it rebuilds a face histogram one die per cycle and evaluates the selected Yacht category. The result is held stable with a valid flag until the inputs change again.

## Interface
Parameters:
- `NUM_DICE`, 5: dice per roll; fixed by game rules and not meant to be overridden.
- `NUM_CAT`, 12: number of categories; legal indices are 0..11.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `dice`, in, 15: packed faces; die *k* is `dice[3k+2:3k]`, legal values 1..6.
- `category_idx`, in, 4: category under selection, driven by the game controller.
- `calc_score`, out, 8: evaluated score for the snapshot; feeds `current_calc_score`.
- `score_valid`, out, 1: high when `calc_score` matches the current inputs.
- `busy`, out, 1: high while in COUNT or EVAL.
- `dice_err`, out, 1: snapshot contained a face of 0 or 7 (see Configuration).

## Operation
- Category map:
  - 0..5, Ones..Sixes: face × count(face).
  - 6, Choice: sum of all dice.
  - 7, Four-of-a-kind: sum of all dice if any count ≥ 4, else 0.
  - 8, Full house: sum of all dice if counts are exactly {3,2}, else 0. A five-of-a-kind does not qualify.
  - 9, Small straight: 15 if {1-4}, {2-5} or {3-6} are all present, else 0.
  - 10, Large straight: 30 if {1-5} or {2-6} are present, else 0.
  - 11, Yacht: 50 if any count = 5, else 0.
  - 12..15: score 0, with `score_valid` still asserted.
- States: IDLE, COUNT, EVAL.
  - **IDLE:** holds result. If `dice`/`category_idx` differ from the snapshot registers, or `start_pending` = 1, then:
    - capture the snapshot;
    - clear the histogram, the die counter and `score_valid`;
    - go to COUNT.
  - **COUNT:** die counter 0..4. Each cycle, increment `hist[face]` for the snapshot die and accumulate the running sum. After die 4, go to EVAL.
  - **EVAL:** compute the score from the histogram and sum, register `calc_score`, set `score_valid`, go to IDLE.
- Restart rule: if live inputs differ from the snapshot while in COUNT or EVAL:
  - recapture the snapshot;
  - clear the histogram, counter and sum;
  - re-enter COUNT at die 0.
  
  EVAL does not publish in that cycle.
- Width rules:
  - Histogram counters: 3 bits each.
  - Sum: 5 bits (max 30).
  - Score: 8 bits; max 50, so no overflow is possible.
  - Face × count is computed as 3 bits × 3 bits into 5 bits (max 30).
- Out-of-range faces (0, 7): not counted in the histogram; their value is still added to the sum.

## Timing
- Reset values:
  - `calc_score` = 0, `score_valid` = 0, `busy` = 0, `dice_err` = 0.
  - state = IDLE.
  - `start_pending` = 1; an evaluation starts automatically after reset release.
  - Snapshot = 0.
- Latency: the input change is seen at edge E. `busy` rises after E. COUNT occupies edges E+1..E+5 and EVAL edge E+6. `score_valid` and `calc_score` update after edge E+6, i.e. 7 cycles.
- `calc_score` keeps its previous value while `score_valid` = 0. Consumers must gate on `score_valid`.
- Simultaneous dice and category change: one restart, not two.
- Reset asserted mid-COUNT: all registers clear immediately (asynchronous). After release, `start_pending` forces a fresh evaluation.

## Configuration
- `YACHT_DICE_RANGE_CHK_EN` defined:
  - `dice_err` is registered in EVAL: 1 if any snapshot face is 0 or 7.
  - When `dice_err` = 1, `calc_score` is forced to 0 and `score_valid` is still set.
- Undefined: `dice_err` is tied to 0 and no check logic is built. Out-of-range faces are handled as described in Operation.

## Structure
- Shared `yacht_pkg`:
  - category index constants (`CAT_ONES`..`CAT_YACHT`);
  - state encoding;
  - `DIE_W` = 3;
  - fixed scores `SCORE_SSTRAIGHT` = 15, `SCORE_LSTRAIGHT` = 30, `SCORE_YACHT` = 50.
  
  The game controller uses the same category constants.
- One sub-module: `yacht_histogram`. It holds the six 3-bit face counters, plus clear and increment-by-face controls. The FSM, sum and EVAL logic stay in the top module.

## Test plan
- Reset release with `dice` = {3,3,3,5,5}, `category_idx` = 8 → `score_valid` rises 7 cycles after release with `calc_score` = 19.
- `dice` = {1,2,3,4,6}, idx 9 → 15; change idx to 10 → `score_valid` drops for 7 cycles, then `calc_score` = 0.
- `dice` = {6,6,6,6,6}: idx 11 → 50; idx 7 → 30; idx 8 → 0; idx 5 → 30.
- Change `dice` from {2,2,2,2,1} to {4,4,4,4,1} during COUNT die 2 with idx 7 → no intermediate publish; the final `calc_score` = 17 arrives 7 cycles after the second change.
- Assert `reset_n` during EVAL → all outputs 0 immediately. After release, with idx 13 → `calc_score` = 0 and `score_valid` = 1.
- With `YACHT_DICE_RANGE_CHK_EN`, `dice` = {0,1,1,1,1}, idx 0 → `dice_err` = 1 and `calc_score` = 0. Without the macro → `dice_err` = 0 and `calc_score` = 4.
